// File: rtl/spi_mem_master.sv
// SPI memory transaction engine: mode-0 command/address/data frames, ROM on spi_cs0, RAM on spi_cs1.
// Define SPI_MEM_WRITE_EN to enable 0x02 write frames; writes aimed at ROM are rejected.
module spi_mem_master #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned CLK_DIV = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              spi_cs0,
  output logic              spi_cs1,
  output logic              spi_clk,
  output logic              spi_mosi,
  input  logic              spi_miso
);
  localparam int unsigned NBITS = 32 + DATA_W;
  localparam int unsigned BIT_W = $clog2(NBITS);
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

`ifdef SPI_MEM_WRITE_EN
  typedef enum logic [2:0] {StIdle, StShift, StHold, StGap, StReject} state_e;
`else
  typedef enum logic [1:0] {StIdle, StShift, StHold, StGap} state_e;
`endif

  state_e            state_q;
  logic [NBITS-1:0]  tx_q;
  logic [DATA_W-1:0] rx_q;
  logic [BIT_W-1:0]  bit_q;
  logic [DIV_W-1:0]  div_q;
  logic [23:0]       byte_addr;
  logic [NBITS-1:0]  frame;
  logic              wr_cur;

  assign byte_addr = 24'({req_addr[ADDR_W-2:0], 1'b0});

`ifdef SPI_MEM_WRITE_EN
  logic wr_q;
  logic err_q;
  logic reject;
  assign reject  = req_we & ~req_addr[ADDR_W-1];
  assign frame   = req_we ? {8'h02, byte_addr, req_wdata} : {8'h03, byte_addr, DATA_W'(0)};
  assign wr_cur  = wr_q;
  assign rsp_err = err_q;
`else
  logic unused_wr;
  assign unused_wr = ^{req_we, req_wdata};
  assign frame     = {8'h03, byte_addr, DATA_W'(0)};
  assign wr_cur    = 1'b0;
  assign rsp_err   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      spi_cs0   <= 1'b1;
      spi_cs1   <= 1'b1;
      spi_clk   <= 1'b0;
      spi_mosi  <= 1'b0;
      tx_q      <= '0;
      rx_q      <= '0;
      bit_q     <= '0;
      div_q     <= '0;
`ifdef SPI_MEM_WRITE_EN
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
`ifdef SPI_MEM_WRITE_EN
            wr_q <= req_we;
            if (reject) begin
              state_q   <= StReject;
              rsp_valid <= 1'b1;
              err_q     <= 1'b1;
              rsp_rdata <= '0;
            end else
`endif
            begin
              state_q  <= StShift;
              spi_cs0  <= req_addr[ADDR_W-1];
              spi_cs1  <= ~req_addr[ADDR_W-1];
              spi_clk  <= 1'b0;
              spi_mosi <= frame[NBITS-1];
              tx_q     <= {frame[NBITS-2:0], 1'b0};
              bit_q    <= '0;
              div_q    <= '0;
            end
          end
        end
        StShift: begin
          if (div_q == DIV_W'(CLK_DIV - 1)) begin
            div_q   <= '0;
            spi_clk <= ~spi_clk;
            // End of high phase: sample miso, then present the next bit as the low phase starts.
            if (spi_clk) begin
              if (bit_q >= BIT_W'(32) && !wr_cur) rx_q <= {rx_q[DATA_W-2:0], spi_miso};
              if (bit_q == BIT_W'(NBITS - 1)) begin
                state_q  <= StHold;
                spi_mosi <= 1'b0;
              end else begin
                bit_q    <= bit_q + 1'b1;
                spi_mosi <= tx_q[NBITS-1];
                tx_q     <= {tx_q[NBITS-2:0], 1'b0};
              end
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        StHold: begin
          state_q   <= StGap;
          spi_cs0   <= 1'b1;
          spi_cs1   <= 1'b1;
          spi_mosi  <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_rdata <= wr_cur ? '0 : rx_q;
`ifdef SPI_MEM_WRITE_EN
          err_q     <= 1'b0;
`endif
        end
        StGap: begin
          state_q   <= StIdle;
          req_ready <= 1'b1;
        end
`ifdef SPI_MEM_WRITE_EN
        StReject: begin
          state_q   <= StIdle;
          req_ready <= 1'b1;
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mem_master.sv
// Directed bench for spi_mem_master: default instance plus a CLK_DIV=3 instance, with an SPI
// target model that returns a per-transaction miso pattern and captures the mosi frame.
module tb_spi_mem_master;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req_valid, req_we, sel;
  logic [15:0] req_addr, req_wdata;
  logic        spi_miso = 1'b0;

  logic        r0_ready, r0_valid, r0_err, cs0_0, cs1_0, sck_0, mosi_0;
  logic [15:0] rdata_0;
  logic        r3_ready, r3_valid, r3_err, cs0_3, cs1_3, sck_3, mosi_3;
  logic [15:0] rdata_3;

  spi_mem_master dut (
    .clk(clk), .rst(rst), .req_valid(req_valid & ~sel), .req_ready(r0_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(r0_valid), .rsp_rdata(rdata_0), .rsp_err(r0_err),
    .spi_cs0(cs0_0), .spi_cs1(cs1_0), .spi_clk(sck_0), .spi_mosi(mosi_0), .spi_miso(spi_miso)
  );

  spi_mem_master #(.CLK_DIV(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid & sel), .req_ready(r3_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(r3_valid), .rsp_rdata(rdata_3), .rsp_err(r3_err),
    .spi_cs0(cs0_3), .spi_cs1(cs1_3), .spi_clk(sck_3), .spi_mosi(mosi_3), .spi_miso(spi_miso)
  );

  logic        m_ready, m_valid, m_err, m_cs0, m_cs1, m_sck, m_mosi, cs_any;
  logic [15:0] m_rdata;
  assign m_ready = sel ? r3_ready : r0_ready;
  assign m_valid = sel ? r3_valid : r0_valid;
  assign m_err   = sel ? r3_err   : r0_err;
  assign m_rdata = sel ? rdata_3  : rdata_0;
  assign m_cs0   = sel ? cs0_3    : cs0_0;
  assign m_cs1   = sel ? cs1_3    : cs1_0;
  assign m_sck   = sel ? sck_3    : sck_0;
  assign m_mosi  = sel ? mosi_3   : mosi_0;
  assign cs_any  = m_cs0 & m_cs1;

  // Target model: frame restarts on CS fall; miso held high during command/address bits.
  int          rise_cnt = 0;
  logic [47:0] mosi_rx  = '0;
  logic [15:0] miso_pat = '0;
  always @(posedge m_sck or negedge cs_any) begin
    if (!m_sck) begin
      rise_cnt = 0;
      mosi_rx  = '0;
    end else begin
      mosi_rx = {mosi_rx[46:0], m_mosi};
      if (rise_cnt < 32) spi_miso = 1'b1;
      else if (rise_cnt < 48) spi_miso = miso_pat[47-rise_cnt];
      rise_cnt++;
    end
  end

  int n_pass = 0, n_total = 0, n_fail = 0;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int          first_low, last_low, valid_cyc, valid_cnt, ready_back, clk_bad, mosi_bad;
  logic        cs0_seen, cs1_seen, got_err;
  logic [15:0] got_rdata;
  int          waited, vcnt;

  task automatic run_txn(input logic use3, input logic we, input logic [15:0] addr,
                         input logic [15:0] wd, input logic [15:0] pat, input int ncyc);
    int   d, span;
    logic expv, low;
    d    = use3 ? 3 : 1;
    span = 2 * d * 48 + 1;
    sel = use3; miso_pat = pat;
    req_we = we; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    first_low = -1; last_low = -1; valid_cyc = -1; valid_cnt = 0; ready_back = -1;
    clk_bad = 0; mosi_bad = 0; cs0_seen = 1'b0; cs1_seen = 1'b0;
    got_rdata = 'x; got_err = 1'bx;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (c == 1) begin
        req_valid = 1'b0; req_we = ~we; req_addr = ~addr; req_wdata = ~wd;
      end
      low = !m_cs0 || !m_cs1;
      if (low && first_low < 0) first_low = c;
      if (low) last_low = c;
      if (!low && m_mosi !== 1'b0) mosi_bad++;
      if (!m_cs0) cs0_seen = 1'b1;
      if (!m_cs1) cs1_seen = 1'b1;
      if (m_valid) begin
        valid_cnt++; valid_cyc = c; got_rdata = m_rdata; got_err = m_err;
      end
      if (m_ready === 1'b1 && ready_back < 0) ready_back = c;
      expv = (((c - 1) / d) % 2) != 0;
      if (c <= span && m_sck !== expv) clk_bad++;
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; sel = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_ready", m_ready, 1);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cs0", m_cs0, 1);
    check("rst_cs1", m_cs1, 1);
    check("rst_sck", m_sck, 0);
    check("rst_mosi", m_mosi, 0);
    check("rst_ready", m_ready, 0);
    check("rst_valid", m_valid, 0);
    check("rst_rdata", m_rdata, 0);
    check("rst_err", m_err, 0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", m_ready, 1);

    // Read ROM 0x0010
    run_txn(1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 99);
    check("rd0_first_low", first_low, 1);
    check("rd0_last_low", last_low, 97);
    check("rd0_valid_cyc", valid_cyc, 98);
    check("rd0_valid_cnt", valid_cnt, 1);
    check("rd0_rdata", got_rdata, 16'hBEEF);
    check("rd0_err", got_err, 0);
    check("rd0_cs0_seen", cs0_seen, 1);
    check("rd0_cs1_seen", cs1_seen, 0);
    check("rd0_rises", rise_cnt, 48);
    check("rd0_mosi", mosi_rx, 48'h0300_0020_0000);
    check("rd0_ready_back", ready_back, 99);
    check("rd0_clk_shape", clk_bad, 0);
    check("rd0_mosi_idle", mosi_bad, 0);
    check("rd0_rdata_hold", m_rdata, 16'hBEEF);

    // Read RAM 0x8001
    run_txn(1'b0, 1'b0, 16'h8001, 16'h0000, 16'h5A3C, 99);
    check("rd1_cs0_seen", cs0_seen, 0);
    check("rd1_cs1_seen", cs1_seen, 1);
    check("rd1_mosi_hdr", mosi_rx[47:16], 32'h0300_0002);
    check("rd1_rdata", got_rdata, 16'h5A3C);
    check("rd1_valid_cyc", valid_cyc, 98);

`ifdef SPI_MEM_WRITE_EN
    run_txn(1'b0, 1'b1, 16'h8004, 16'h1234, 16'hFFFF, 99);
    check("wr_mosi", mosi_rx, 48'h0200_0008_1234);
    check("wr_rdata", got_rdata, 0);
    check("wr_err", got_err, 0);
    check("wr_valid_cyc", valid_cyc, 98);
    check("wr_cs1_seen", cs1_seen, 1);
    run_txn(1'b0, 1'b1, 16'h0004, 16'h5555, 16'h0000, 3);
    check("rej_valid_cyc", valid_cyc, 1);
    check("rej_valid_cnt", valid_cnt, 1);
    check("rej_err", got_err, 1);
    check("rej_no_cs", first_low, -1);
    check("rej_ready_back", ready_back, 2);
    check("rej_mosi_idle", mosi_bad, 0);
`else
    // Without write support req_we is ignored and the request is a plain read
    run_txn(1'b0, 1'b1, 16'h0004, 16'h1234, 16'h0F0F, 99);
    check("we_ign_mosi", mosi_rx, 48'h0300_0008_0000);
    check("we_ign_rdata", got_rdata, 16'h0F0F);
    check("we_ign_err", got_err, 0);
    check("we_ign_cs0", cs0_seen, 1);
`endif

    // CLK_DIV = 3 instance
    run_txn(1'b1, 1'b0, 16'h0000, 16'h0000, 16'hC001, 291);
    check("d3_first_low", first_low, 1);
    check("d3_last_low", last_low, 289);
    check("d3_valid_cyc", valid_cyc, 290);
    check("d3_ready_back", ready_back, 291);
    check("d3_clk_shape", clk_bad, 0);
    check("d3_rises", rise_cnt, 48);
    check("d3_rdata", got_rdata, 16'hC001);
    check("d3_cs0_seen", cs0_seen, 1);

    // Reset at the 20th spi_clk rising edge of a read
    sel = 1'b0; miso_pat = 16'hFFFF; req_we = 1'b0; req_addr = 16'h0010; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    waited = 0;
    while (rise_cnt < 20 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("mid_rise20", rise_cnt, 20);
    rst = 1'b1;
    @(negedge clk);
    check("mid_cs0", m_cs0, 1);
    check("mid_cs1", m_cs1, 1);
    check("mid_sck", m_sck, 0);
    check("mid_mosi", m_mosi, 0);
    check("mid_ready", m_ready, 0);
    check("mid_rdata", m_rdata, 0);
    rst = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 110; i++) begin
      @(negedge clk);
      if (m_valid) vcnt++;
    end
    check("mid_no_valid", vcnt, 0);

    run_txn(1'b0, 1'b0, 16'h8002, 16'h0000, 16'h1357, 99);
    check("post_mosi_hdr", mosi_rx[47:16], 32'h0300_0004);
    check("post_rdata", got_rdata, 16'h1357);
    check("post_cs1_seen", cs1_seen, 1);
    check("post_valid_cyc", valid_cyc, 98);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
